// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-requester round-robin arbiter for a single-port on-chip RAM
//
// Purpose: serialises two Avalon-MM-style requesters (m0, m1) onto one
// single-port RAM with 1-cycle read latency, steers read data back to the
// requester that issued the read, and optionally zero-fills the RAM after
// reset before any request is granted.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m{0,1}_address/byteenable/
//   read/write/writedata         requester inputs
//   m{0,1}_waitrequest           high = request not accepted this cycle
//   m{0,1}_readdata/datavalid    read return, valid one cycle after grant
//   mem_*                        RAM address/byteenable/chipselect/write/writedata
//   mem_readdata                 RAM q, valid one cycle after a read issues
//   init_done                    high once the clear sweep has finished

module onchip_mem_arbiter #(
  parameter int ADDR_W         = 14,
  parameter int DEPTH          = 16384,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,

  output logic              init_done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_owner_q, rd_owner_d;
  logic             init_done_q, init_done_d;

  logic             req0, req1;
  logic             gnt_vld;
  logic             gnt_idx;
  logic             gnt_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      init_done_q  <= init_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    last_grant_d   = last_grant_q;
    rd_pend_d      = 1'b0;
    rd_owner_d     = rd_owner_q;
    init_done_d    = init_done_q;

    req0           = m0_read | m0_write;
    req1           = m1_read | m1_write;
    gnt_vld        = 1'b0;
    gnt_idx        = 1'b0;
    gnt_write      = 1'b0;

    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = 32'h0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = ADDR_W'(clr_cnt_q);
        mem_byteenable = 4'hF;
        // Counter parks on the last address so it can never wrap.
        if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        init_done_d = 1'b1;
        gnt_vld     = req0 | req1;
        // Under contention the port that did not win last time wins now;
        // otherwise whichever single port is requesting wins.
        gnt_idx     = (req0 && req1) ? ~last_grant_q : req1;
        gnt_write   = gnt_idx ? m1_write : m0_write;

        if (gnt_vld) begin
          mem_chipselect = 1'b1;
          mem_write      = gnt_write;
          mem_address    = gnt_idx ? m1_address    : m0_address;
          mem_byteenable = gnt_idx ? m1_byteenable : m0_byteenable;
          mem_writedata  = gnt_idx ? m1_writedata  : m0_writedata;
          m0_waitrequest = gnt_idx;
          m1_waitrequest = ~gnt_idx;
          last_grant_d   = gnt_idx;
          // read+write together is a write: no return data follows
          rd_pend_d      = ~gnt_write;
          rd_owner_d     = gnt_idx;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Keep the RAM quiet and both ports stalled while reset is held,
    // independent of the state the FSM is reset into.
    if (!reset_n) begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q &  rd_owner_q;
  assign init_done        = init_done_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - self-checking bench for onchip_mem_arbiter

module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // DUT A: DEPTH=16, clear on reset
  logic        rst_a;
  logic [3:0]  a_m0_address, a_m0_byteenable, a_m1_address, a_m1_byteenable;
  logic        a_m0_read, a_m0_write, a_m1_read, a_m1_write;
  logic [31:0] a_m0_writedata, a_m1_writedata;
  logic        a_m0_waitrequest, a_m1_waitrequest, a_m0_rv, a_m1_rv;
  logic [31:0] a_m0_readdata, a_m1_readdata;
  logic [3:0]  a_mem_address, a_mem_byteenable;
  logic        a_mem_chipselect, a_mem_write, a_init_done;
  logic [31:0] a_mem_writedata, a_mem_readdata;

  // DUT B: DEPTH=16, no clear
  logic        rst_b;
  logic [3:0]  b_m0_address, b_m0_byteenable, b_m1_address, b_m1_byteenable;
  logic        b_m0_read, b_m0_write, b_m1_read, b_m1_write;
  logic [31:0] b_m0_writedata, b_m1_writedata;
  logic        b_m0_waitrequest, b_m1_waitrequest, b_m0_rv, b_m1_rv;
  logic [31:0] b_m0_readdata, b_m1_readdata;
  logic [3:0]  b_mem_address, b_mem_byteenable;
  logic        b_mem_chipselect, b_mem_write, b_init_done;
  logic [31:0] b_mem_writedata, b_mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1'b1)) u_dut_a (
    .clk(clk), .reset_n(rst_a),
    .m0_address(a_m0_address), .m0_byteenable(a_m0_byteenable), .m0_read(a_m0_read),
    .m0_write(a_m0_write), .m0_writedata(a_m0_writedata), .m0_waitrequest(a_m0_waitrequest),
    .m0_readdata(a_m0_readdata), .m0_readdatavalid(a_m0_rv),
    .m1_address(a_m1_address), .m1_byteenable(a_m1_byteenable), .m1_read(a_m1_read),
    .m1_write(a_m1_write), .m1_writedata(a_m1_writedata), .m1_waitrequest(a_m1_waitrequest),
    .m1_readdata(a_m1_readdata), .m1_readdatavalid(a_m1_rv),
    .mem_address(a_mem_address), .mem_byteenable(a_mem_byteenable),
    .mem_chipselect(a_mem_chipselect), .mem_write(a_mem_write),
    .mem_writedata(a_mem_writedata), .mem_readdata(a_mem_readdata),
    .init_done(a_init_done)
  );

  onchip_mem_arbiter #(.ADDR_W(4), .DEPTH(16), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clk(clk), .reset_n(rst_b),
    .m0_address(b_m0_address), .m0_byteenable(b_m0_byteenable), .m0_read(b_m0_read),
    .m0_write(b_m0_write), .m0_writedata(b_m0_writedata), .m0_waitrequest(b_m0_waitrequest),
    .m0_readdata(b_m0_readdata), .m0_readdatavalid(b_m0_rv),
    .m1_address(b_m1_address), .m1_byteenable(b_m1_byteenable), .m1_read(b_m1_read),
    .m1_write(b_m1_write), .m1_writedata(b_m1_writedata), .m1_waitrequest(b_m1_waitrequest),
    .m1_readdata(b_m1_readdata), .m1_readdatavalid(b_m1_rv),
    .mem_address(b_mem_address), .mem_byteenable(b_mem_byteenable),
    .mem_chipselect(b_mem_chipselect), .mem_write(b_mem_write),
    .mem_writedata(b_mem_writedata), .mem_readdata(b_mem_readdata),
    .init_done(b_init_done)
  );

  // RAM behind DUT A: 1-cycle read latency, byte-lane writes
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (a_mem_chipselect) begin
      if (a_mem_write) begin
        for (int b = 0; b < 4; b++)
          if (a_mem_byteenable[b]) ram[a_mem_address][8*b +: 8] <= a_mem_writedata[8*b +: 8];
      end else begin
        a_mem_readdata <= ram[a_mem_address];
      end
    end
  end
  assign b_mem_readdata = 32'h0;

  int  n_pass = 0;
  int  n_tot  = 0;
  bit  done   = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void chkb(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
  endfunction

  // Reference model of DUT A: a sweep counter, the last-served requester,
  // a shadow of the RAM contents and the one outstanding read response.
  int          m_cnt  = 0;
  bit          m_last = 1'b1;
  bit          m_rv   = 1'b0;
  bit          m_ro   = 1'b0;
  logic [31:0] m_rd   = 32'h0;
  logic [31:0] m_mem [16];

  initial begin
    logic        e_wr0, e_wr1, e_cs, e_we, e_init;
    logic [3:0]  e_addr, e_be;
    logic [31:0] e_wd, mask;
    bit          r0, r1, who, srv, wr;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (!rst_a) begin
          m_cnt = 0; m_last = 1'b1; m_rv = 1'b0;
          chkb("m_rst_wait0", a_m0_waitrequest, 1'b1);
          chkb("m_rst_wait1", a_m1_waitrequest, 1'b1);
          chkb("m_rst_cs", a_mem_chipselect, 1'b0);
          chkb("m_rst_we", a_mem_write, 1'b0);
          chkb("m_rst_rv0", a_m0_rv, 1'b0);
          chkb("m_rst_rv1", a_m1_rv, 1'b0);
          chkb("m_rst_init", a_init_done, 1'b0);
        end else begin
          e_wr0 = 1'b1; e_wr1 = 1'b1; e_cs = 1'b0; e_we = 1'b0;
          e_addr = 4'h0; e_be = 4'h0; e_wd = 32'h0;
          srv = 1'b0; who = 1'b0; wr = 1'b0;
          e_init = (m_cnt >= 16);
          if (m_cnt < 16) begin
            e_cs = 1'b1; e_we = 1'b1; e_addr = 4'(m_cnt); e_be = 4'hF;
          end else begin
            r0  = a_m0_read | a_m0_write;
            r1  = a_m1_read | a_m1_write;
            srv = r0 | r1;
            who = (r0 && r1) ? !m_last : r1;
            if (srv) begin
              wr     = who ? a_m1_write : a_m0_write;
              e_cs   = 1'b1;
              e_we   = wr;
              e_addr = who ? a_m1_address    : a_m0_address;
              e_be   = who ? a_m1_byteenable : a_m0_byteenable;
              e_wd   = who ? a_m1_writedata  : a_m0_writedata;
              if (who) e_wr1 = 1'b0; else e_wr0 = 1'b0;
            end
          end
          chkb("m_wait0", a_m0_waitrequest, e_wr0);
          chkb("m_wait1", a_m1_waitrequest, e_wr1);
          chkb("m_cs", a_mem_chipselect, e_cs);
          chkb("m_we", a_mem_write, e_we);
          chkb("m_init", a_init_done, e_init);
          chkb("m_rv0", a_m0_rv, m_rv && !m_ro);
          chkb("m_rv1", a_m1_rv, m_rv && m_ro);
          if (e_cs) begin
            chk("m_addr", {28'd0, a_mem_address}, {28'd0, e_addr});
            chk("m_be", {28'd0, a_mem_byteenable}, {28'd0, e_be});
            if (e_we) chk("m_wd", a_mem_writedata, e_wd);
          end
          if (m_rv) chk("m_rdata", m_ro ? a_m1_readdata : a_m0_readdata, m_rd);

          m_rv = 1'b0;
          if (m_cnt < 16) begin
            m_mem[4'(m_cnt)] = 32'h0;
            m_cnt++;
          end else if (srv) begin
            m_last = who;
            if (wr) begin
              for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{e_be[b]}};
              m_mem[e_addr] = (m_mem[e_addr] & ~mask) | (e_wd & mask);
            end else begin
              m_rv = 1'b1; m_ro = who; m_rd = m_mem[e_addr];
            end
          end
        end
      end
    end
  end

  task automatic acc(input bit p, input bit wr, input logic [3:0] ad, input logic [3:0] be,
                     input logic [31:0] d, output logic [31:0] rd);
    @(posedge clk); #1;
    if (p) begin
      a_m1_read = !wr; a_m1_write = wr; a_m1_address = ad; a_m1_byteenable = be; a_m1_writedata = d;
    end else begin
      a_m0_read = !wr; a_m0_write = wr; a_m0_address = ad; a_m0_byteenable = be; a_m0_writedata = d;
    end
    @(negedge clk);
    chkb("acc_wait", p ? a_m1_waitrequest : a_m0_waitrequest, 1'b0);
    @(posedge clk); #1;
    a_m0_read = 1'b0; a_m0_write = 1'b0; a_m1_read = 1'b0; a_m1_write = 1'b0;
    rd = 32'h0;
    if (!wr) begin
      @(negedge clk);
      chkb("acc_rv", p ? a_m1_rv : a_m0_rv, 1'b1);
      chkb("acc_rv_other", p ? a_m0_rv : a_m1_rv, 1'b0);
      rd = p ? a_m1_readdata : a_m0_readdata;
    end
  endtask

  task automatic sweep(input string nm);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk({nm, "_addr"}, {28'd0, a_mem_address}, 32'(k));
      chkb({nm, "_we"}, a_mem_write, 1'b1);
      chkb({nm, "_init"}, a_init_done, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  gp, vp;
    int          vcnt;

    rst_a = 1'b0; rst_b = 1'b0;
    a_m0_address = 4'h0; a_m0_byteenable = 4'hF; a_m0_read = 1'b0; a_m0_write = 1'b0; a_m0_writedata = 32'h0;
    a_m1_address = 4'h0; a_m1_byteenable = 4'hF; a_m1_read = 1'b0; a_m1_write = 1'b0; a_m1_writedata = 32'h0;
    b_m0_address = 4'h3; b_m0_byteenable = 4'hF; b_m0_read = 1'b0; b_m0_write = 1'b1; b_m0_writedata = 32'h12345678;
    b_m1_address = 4'h0; b_m1_byteenable = 4'hF; b_m1_read = 1'b0; b_m1_write = 1'b0; b_m1_writedata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("b_rst_wait0", b_m0_waitrequest, 1'b0 == 1'b1 ? 1'b0 : 1'b1);
    chkb("b_rst_memwr", b_mem_write, 1'b0);
    chkb("b_rst_init", b_init_done, 1'b0);
    chkb("a_rst_init", a_init_done, 1'b0);

    // Release A with an m0 read pending: it must stall through the sweep.
    @(posedge clk); #1;
    rst_a = 1'b1; a_m0_read = 1'b1; a_m0_address = 4'h3;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("sweep_addr", {28'd0, a_mem_address}, 32'(k));
      chkb("sweep_we", a_mem_write, 1'b1);
      chk("sweep_wd", a_mem_writedata, 32'h0);
      chkb("sweep_wait0", a_m0_waitrequest, 1'b1);
      chkb("sweep_init", a_init_done, 1'b0);
    end
    @(posedge clk); #1;
    a_m0_read = 1'b0;
    @(negedge clk);
    chkb("init_rise", a_init_done, 1'b1);

    acc(1'b0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF, rd);
    acc(1'b0, 1'b0, 4'd5, 4'hF, 32'h0, rd);
    chk("rd5_m0", rd, 32'hDEADBEEF);

    acc(1'b1, 1'b1, 4'd7, 4'b0001, 32'h000000AA, rd);
    acc(1'b1, 1'b0, 4'd7, 4'hF, 32'h0, rd);
    chk("rd7_lane0", rd, 32'h000000AA);

    acc(1'b0, 1'b1, 4'd7, 4'b1100, 32'h11223344, rd);
    acc(1'b0, 1'b0, 4'd7, 4'hF, 32'h0, rd);
    chk("rd7_lanes32", rd, 32'h112200AA);

    // read and write together on m0 behave as a write
    @(posedge clk); #1;
    a_m0_read = 1'b1; a_m0_write = 1'b1; a_m0_address = 4'd9; a_m0_byteenable = 4'hF; a_m0_writedata = 32'h55;
    @(negedge clk);
    chkb("rw_wait0", a_m0_waitrequest, 1'b0);
    chkb("rw_memwr", a_mem_write, 1'b1);
    @(posedge clk); #1;
    a_m0_read = 1'b0; a_m0_write = 1'b0;
    @(negedge clk);
    chkb("rw_no_rv", a_m0_rv, 1'b0);
    acc(1'b0, 1'b0, 4'd9, 4'hF, 32'h0, rd);
    chk("rd9", rd, 32'h55);

    // last grant goes to m1 so contention starts with m0
    acc(1'b1, 1'b0, 4'd7, 4'hF, 32'h0, rd);
    chk("rd7_m1", rd, 32'h112200AA);

    @(posedge clk); #1;
    a_m0_read = 1'b1; a_m0_address = 4'd1;
    a_m1_read = 1'b1; a_m1_address = 4'd2;
    gp = 6'h0; vp = 6'h0; vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gp[i] = !a_m1_waitrequest;
      chkb("cont_onegrant", a_m0_waitrequest ^ a_m1_waitrequest, 1'b1);
      if (i > 0) begin
        vp[i-1] = a_m1_rv;
        vcnt += int'(a_m0_rv) + int'(a_m1_rv);
      end
    end
    @(posedge clk); #1;
    a_m0_read = 1'b0; a_m1_read = 1'b0;
    @(negedge clk);
    vp[5] = a_m1_rv;
    vcnt += int'(a_m0_rv) + int'(a_m1_rv);
    chk("cont_grants", {26'd0, gp}, 32'h2A);
    chk("cont_valids", {26'd0, vp}, 32'h2A);
    chk("cont_vcount", 32'(vcnt), 32'd6);

    // reset lands in the cycle after an m1 read is granted
    @(posedge clk); #1;
    a_m1_read = 1'b1; a_m1_address = 4'd7;
    @(negedge clk);
    chkb("pulse_wait1", a_m1_waitrequest, 1'b0);
    @(posedge clk); #1;
    a_m1_read = 1'b0; rst_a = 1'b0;
    @(negedge clk);
    chkb("pulse_rv1", a_m1_rv, 1'b0);
    chkb("pulse_memwr", a_mem_write, 1'b0);
    chkb("pulse_init", a_init_done, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chkb("pulse_rv1_late", a_m1_rv, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("part_addr", {28'd0, a_mem_address}, 32'(k));
      chkb("part_init", a_init_done, 1'b0);
    end
    // reset again in the middle of the sweep
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    chkb("midsweep_memwr", a_mem_write, 1'b0);
    chkb("midsweep_cs", a_mem_chipselect, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    sweep("resweep");
    @(negedge clk);
    chkb("reinit_rise", a_init_done, 1'b1);
    acc(1'b0, 1'b0, 4'd5, 4'hF, 32'h0, rd);
    chk("rd5_after_clear", rd, 32'h0);

    // DUT B: no sweep, first cycle after release is already RUN with init_done
    @(posedge clk); #1;
    b_m0_write = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    b_m0_write = 1'b1;
    @(negedge clk);
    chkb("b_init", b_init_done, 1'b1);
    chkb("b_wait0", b_m0_waitrequest, 1'b0);
    chkb("b_wait1", b_m1_waitrequest, 1'b1);
    chkb("b_memwr", b_mem_write, 1'b1);
    chk("b_addr", {28'd0, b_mem_address}, 32'd3);
    chk("b_wd", b_mem_writedata, 32'h12345678);
    @(posedge clk); #1;
    b_m0_write = 1'b0;

    done = 1'b1;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 32-bit single-port on-chip RAM in the Nios II subsystem (16384 words, byte enables, 1-cycle read latency).
- Exposes two Avalon-MM-style slave ports (m0, m1) and drives the RAM's address, byteenable, chipselect, write and writedata.
- Routes returned read data back to the requester that issued the read.
- Optionally zero-fills the whole RAM after reset, before granting any access.

Parameters:
ADDR_W, 14, word address width.
DEPTH, 16384, number of words; the clear sweep covers addresses 0..DEPTH-1.
CLEAR_ON_RESET, 1, 1 = zero-fill after reset; 0 = go straight to RUN.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
m0_address  in  ADDR_W  requester 0 word address.
m0_byteenable  in  4  requester 0 byte lanes.
m0_read  in  1  requester 0 read request.
m0_write  in  1  requester 0 write request.
m0_writedata  in  32  requester 0 write data.
m0_waitrequest  out  1  high = request not accepted this cycle.
m0_readdata  out  32  read data to requester 0.
m0_readdatavalid  out  1  read data valid for requester 0.
m1_*  same set as m0_* for requester 1.
mem_address  out  ADDR_W  RAM address.
mem_byteenable  out  4  RAM byte enables.
mem_chipselect  out  1  RAM select.
mem_write  out  1  RAM write strobe.
mem_writedata  out  32  RAM write data.
mem_readdata  in  32  RAM q, valid 1 cycle after the read is issued.
init_done  out  1  high once the clear sweep is complete (or immediately if CLEAR_ON_RESET=0).

Behaviour:
Reset values:
- FSM = CLEAR if CLEAR_ON_RESET, else RUN.
- clr_cnt=0, last_grant=1, rd_pend=0, rd_owner=0, init_done=0.
- mem_chipselect=0, mem_write=0.
- m*_waitrequest=1, m*_readdatavalid=0.

CLEAR state:
- Each cycle: mem_chipselect=1, mem_write=1, mem_address=clr_cnt, mem_byteenable=4'hF, mem_writedata=0.
- clr_cnt increments by 1 per cycle.
- Both waitrequests held high; requests are ignored, not queued.
- Exit: in the cycle clr_cnt==DEPTH-1 the last write issues. Next cycle FSM=RUN and init_done=1 (registered). Exactly DEPTH writes; clr_cnt never wraps.

RUN state:
- req_i = m_i_read | m_i_write.
- Grant is combinational within the same cycle:
  - Only one requester active: it is granted.
  - Both active: grant the requester != last_grant.
  - Neither active: no grant, mem_chipselect=0.
- Granted port: its waitrequest=0 in that cycle. Its address, byteenable and writedata drive the mem_* outputs; mem_chipselect=1; mem_write=m_i_write.
- Losing or idle port: waitrequest=1.
- last_grant updates to the granted index on every grant; it holds when there is no grant.
- Under continuous contention, grants alternate strictly, so the maximum wait is 1 cycle.
- init_done stays 1 until the next reset.

Reads:
- A granted read with write=0 sets rd_pend=1 and rd_owner=granted index (registered).
- In the following cycle, m{rd_owner}_readdatavalid=1 for exactly 1 cycle; the other port's readdatavalid=0.
- m0_readdata = m1_readdata = mem_readdata (combinational); meaningful only while that port's readdatavalid is high.
- Back-to-back reads are fully pipelined: one read issues per cycle and one readdatavalid fires per cycle, 1 cycle behind.

Boundary conditions:
- Read and write both high on one port: treated as a write. No readdatavalid follows.
- Write followed by a read to the same address on the next grant: the read returns the new data. RAM write-then-read ordering is preserved because accesses are serialised.
- Reset asserted mid-operation:
  - All state clears asynchronously; any pending readdatavalid is dropped.
  - A clear sweep in progress restarts from 0 after reset deasserts.
  - mem_write deasserts immediately when reset asserts.
- Requests during CLEAR receive no response other than waitrequest=1.
- Address is not range-checked; ADDR_W bits pass through unmodified.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1, release reset -> 16 consecutive mem_write pulses on addresses 0..15 with data 0 and byteenable F; init_done rises the cycle after address 15; m0 read asserted during the sweep sees waitrequest=1 throughout.
- RUN, m0 writes 0xDEADBEEF to address 5 (byteenable F), then reads address 5 -> each accepted with waitrequest=0; m0_readdatavalid=1 one cycle after the read with readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: m1 writes 0x000000AA with byteenable 4'b0001 to address 7 over a cleared word, then reads address 7 -> returns 0x000000AA.
- m0 and m1 both assert read continuously for 6 cycles (addresses 1 and 2) -> grants alternate m0,m1,m0,m1,m0,m1; readdatavalid alternates the same way 1 cycle later; no dropped or duplicated valids.
- Reset pulsed low in the cycle after an m1 read is granted -> m1_readdatavalid never asserts; after release, the sweep restarts at address 0 and init_done=0 until it completes.
- CLEAR_ON_RESET=0 -> init_done=1 the first cycle after reset release; an m0 write in that cycle is accepted immediately.
